// File: rtl/ram8k_arbiter_if.sv
// Bus bundle between two requesters (A = CPU data side, B = DMA/loader),
// the arbiter and a single-port synchronous RAM.
//   a_*/b_* : req/rnw/addr/wdata toward the arbiter, ack/rvalid/rdata back
//   ram_*   : cs/rnw/addr/din toward the RAM, dout back from the RAM
// slave  modport: the arbiter's view.
// master modport: the surrounding requesters and RAM macro.
interface ram8k_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic              a_req;
  logic              a_rnw;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_rnw;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_cs;
  logic              ram_rnw;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  a_req, a_rnw, a_addr, a_wdata,
    output a_ack, a_rvalid, a_rdata,
    input  b_req, b_rnw, b_addr, b_wdata,
    output b_ack, b_rvalid, b_rdata,
    output ram_cs, ram_rnw, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output a_req, a_rnw, a_addr, a_wdata,
    input  a_ack, a_rvalid, a_rdata,
    output b_req, b_rnw, b_addr, b_wdata,
    input  b_ack, b_rvalid, b_rdata,
    input  ram_cs, ram_rnw, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/ram8k_arbiter.sv
// Two-port arbiter sharing one 8192x32 single-port synchronous RAM.
// Grant, ack and the RAM command are combinational in the request cycle;
// read data comes back on the owning port one cycle later with rvalid.
// Ports:
//   clk    : clock
//   resetb : synchronous active-low reset; forces every output to 0
//   bus    : ram8k_arbiter_if.slave (port A, port B and RAM signals)
// Parameters:
//   ADDR_W  : RAM word address width
//   DATA_W  : data width
//   RR_MODE : 1 = round-robin on contention, 0 = fixed priority (A wins)
module ram8k_arbiter #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 32,
  parameter bit          RR_MODE = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetb,
  ram8k_arbiter_if.slave        bus
);

  logic              last_b;
  logic              granted_once;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] din_hold;
  logic              rd_pend;
  logic              rd_owner_b;

  logic              grant_a_c;
  logic              grant_b_c;
  logic              a_rv_c;
  logic              b_rv_c;

  // Port selection. Until the first grant after reset B counts as last
  // granted, so A wins the first contention even though last_b resets to 0.
  always_comb begin : grant_sel
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (resetb) begin
      case ({bus.a_req, bus.b_req})
        2'b10:   grant_a_c = 1'b1;
        2'b01:   grant_b_c = 1'b1;
        2'b11: begin
          if (RR_MODE && granted_once && !last_b) grant_b_c = 1'b1;
          else                                    grant_a_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read return strobes come from the owner/flag flops captured at grant.
  assign a_rv_c = resetb & rd_pend & ~rd_owner_b;
  assign b_rv_c = resetb & rd_pend &  rd_owner_b;

  // Acks, RAM command mux and read data steering.
  always_comb begin : out_drive
    bus.a_ack    = grant_a_c;
    bus.b_ack    = grant_b_c;
    bus.ram_cs   = grant_a_c | grant_b_c;
    bus.ram_rnw  = resetb;
    bus.ram_addr = resetb ? addr_hold : '0;
    bus.ram_din  = resetb ? din_hold  : '0;
    if (grant_a_c) begin
      bus.ram_rnw  = bus.a_rnw;
      bus.ram_addr = bus.a_addr;
      bus.ram_din  = bus.a_wdata;
    end else if (grant_b_c) begin
      bus.ram_rnw  = bus.b_rnw;
      bus.ram_addr = bus.b_addr;
      bus.ram_din  = bus.b_wdata;
    end
    bus.a_rvalid = a_rv_c;
    bus.b_rvalid = b_rv_c;
    bus.a_rdata  = a_rv_c ? bus.ram_dout : '0;
    bus.b_rdata  = b_rv_c ? bus.ram_dout : '0;
  end

  // Pointer, idle-hold of the RAM address/data, and pending-read tracking.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      last_b       <= 1'b0;
      granted_once <= 1'b0;
      addr_hold    <= '0;
      din_hold     <= '0;
      rd_pend      <= 1'b0;
      rd_owner_b   <= 1'b0;
    end else begin
      if (grant_a_c || grant_b_c) begin
        last_b       <= grant_b_c;
        granted_once <= 1'b1;
        addr_hold    <= bus.ram_addr;
        din_hold     <= bus.ram_din;
      end
      rd_pend    <= (grant_a_c & bus.a_rnw) | (grant_b_c & bus.b_rnw);
      rd_owner_b <= grant_b_c;
    end
  end

endmodule

// File: tb/tb_ram8k_arbiter.sv
// Bench for ram8k_arbiter: one round-robin and one fixed-priority instance,
// each with its own RAM model, run against a cycle-level reference model.
module tb_ram8k_arbiter;
  localparam int unsigned AW    = 13;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic          req;
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } rq_t;

  logic clk = 1'b0;
  logic resetb;
  always #5 clk = ~clk;

  ram8k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_rr ();
  ram8k_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_fx ();

  ram8k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .resetb(resetb), .bus(if_rr.slave));
  ram8k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b0)) u_fx (
    .clk(clk), .resetb(resetb), .bus(if_fx.slave));

  // index [d][p]: d = 0 round-robin instance, 1 fixed; p = 0 port A, 1 port B
  rq_t           rq     [2][2];
  logic          ack_o  [2][2];
  logic          rv_o   [2][2];
  logic [DW-1:0] rd_o   [2][2];
  logic          cs_o   [2];
  logic          rnw_o  [2];
  logic [AW-1:0] addr_o [2];
  logic [DW-1:0] din_o  [2];
  logic [DW-1:0] dout   [2];

  assign if_rr.a_req = rq[0][0].req;   assign if_rr.a_rnw   = rq[0][0].rnw;
  assign if_rr.a_addr = rq[0][0].addr; assign if_rr.a_wdata = rq[0][0].wdata;
  assign if_rr.b_req = rq[0][1].req;   assign if_rr.b_rnw   = rq[0][1].rnw;
  assign if_rr.b_addr = rq[0][1].addr; assign if_rr.b_wdata = rq[0][1].wdata;
  assign if_fx.a_req = rq[1][0].req;   assign if_fx.a_rnw   = rq[1][0].rnw;
  assign if_fx.a_addr = rq[1][0].addr; assign if_fx.a_wdata = rq[1][0].wdata;
  assign if_fx.b_req = rq[1][1].req;   assign if_fx.b_rnw   = rq[1][1].rnw;
  assign if_fx.b_addr = rq[1][1].addr; assign if_fx.b_wdata = rq[1][1].wdata;
  assign if_rr.ram_dout = dout[0];
  assign if_fx.ram_dout = dout[1];

  assign ack_o[0][0] = if_rr.a_ack;    assign ack_o[0][1] = if_rr.b_ack;
  assign rv_o[0][0]  = if_rr.a_rvalid; assign rv_o[0][1]  = if_rr.b_rvalid;
  assign rd_o[0][0]  = if_rr.a_rdata;  assign rd_o[0][1]  = if_rr.b_rdata;
  assign ack_o[1][0] = if_fx.a_ack;    assign ack_o[1][1] = if_fx.b_ack;
  assign rv_o[1][0]  = if_fx.a_rvalid; assign rv_o[1][1]  = if_fx.b_rvalid;
  assign rd_o[1][0]  = if_fx.a_rdata;  assign rd_o[1][1]  = if_fx.b_rdata;
  assign cs_o[0] = if_rr.ram_cs;   assign rnw_o[0] = if_rr.ram_rnw;
  assign addr_o[0] = if_rr.ram_addr; assign din_o[0] = if_rr.ram_din;
  assign cs_o[1] = if_fx.ram_cs;   assign rnw_o[1] = if_fx.ram_rnw;
  assign addr_o[1] = if_fx.ram_addr; assign din_o[1] = if_fx.ram_din;

  // Single-port synchronous RAM: write commits at the edge, read data next cycle.
  logic [DW-1:0] mem [2][DEPTH];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cs_o[d]) begin
        if (rnw_o[d]) dout[d] <= mem[d][addr_o[d]];
        else          mem[d][addr_o[d]] <= din_o[d];
      end
    end
  end

  // Reference model state
  int            last_port [2];      // 0 = A, 1 = B; reset means "B was last"
  logic          pv_m  [2];          // read return expected this cycle
  int            pp_m  [2];          // owning port of that return
  logic          pk_m  [2];          // returned data is known
  logic [DW-1:0] pd_m  [2];
  logic [AW-1:0] ha_m  [2];          // last driven RAM address / data
  logic [DW-1:0] hd_m  [2];
  logic [DW-1:0] ref_mem [2][DEPTH];
  logic          seen    [2][DEPTH];
  logic          acked [2][2];
  logic          lack  [2][2];       // observations from the latest cycle
  logic          lrv   [2][2];
  logic [DW-1:0] lrd   [2][2];

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int exp_grant(input int d);
    logic a, b;
    a = rq[d][0].req;
    b = rq[d][1].req;
    if (!resetb)    return -1;
    if (a && b)     return (d == 0) ? 1 - last_port[d] : 0;
    if (a)          return 0;
    if (b)          return 1;
    return -1;
  endfunction

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int g [2];
    string p;
    logic erv;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      p = (d == 0) ? "rr" : "fx";
      g[d] = exp_grant(d);
      for (int q = 0; q < 2; q++) begin
        lack[d][q] = ack_o[d][q];
        lrv[d][q]  = rv_o[d][q];
        lrd[d][q]  = rd_o[d][q];
      end
      if (!resetb) begin
        for (int q = 0; q < 2; q++) begin
          check($sformatf("%s_rst_ack%0d", p, q), 32'(ack_o[d][q]), 32'd0);
          check($sformatf("%s_rst_rv%0d", p, q),  32'(rv_o[d][q]), 32'd0);
          check($sformatf("%s_rst_rd%0d", p, q),  rd_o[d][q], 32'd0);
        end
        check({p, "_rst_cs"},   32'(cs_o[d]), 32'd0);
        check({p, "_rst_rnw"},  32'(rnw_o[d]), 32'd0);
        check({p, "_rst_addr"}, 32'(addr_o[d]), 32'd0);
        check({p, "_rst_din"},  din_o[d], 32'd0);
      end else begin
        check({p, "_a_ack"}, 32'(ack_o[d][0]), 32'(g[d] == 0));
        check({p, "_b_ack"}, 32'(ack_o[d][1]), 32'(g[d] == 1));
        check({p, "_cs"},    32'(cs_o[d]), 32'(g[d] >= 0));
        if (g[d] >= 0) begin
          check({p, "_rnw"},  32'(rnw_o[d]), 32'(rq[d][g[d]].rnw));
          check({p, "_addr"}, 32'(addr_o[d]), 32'(rq[d][g[d]].addr));
          check({p, "_din"},  din_o[d], rq[d][g[d]].wdata);
        end else begin
          check({p, "_idle_rnw"},  32'(rnw_o[d]), 32'd1);
          check({p, "_idle_addr"}, 32'(addr_o[d]), 32'(ha_m[d]));
          check({p, "_idle_din"},  din_o[d], hd_m[d]);
        end
        for (int q = 0; q < 2; q++) begin
          erv = pv_m[d] && (pp_m[d] == q);
          check($sformatf("%s_rv%0d", p, q), 32'(rv_o[d][q]), 32'(erv));
          if (!erv)          check($sformatf("%s_rd0_%0d", p, q), rd_o[d][q], 32'd0);
          else if (pk_m[d])  check($sformatf("%s_rd%0d", p, q), rd_o[d][q], pd_m[d]);
        end
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!resetb) begin
        last_port[d] = 1;
        pv_m[d] = 1'b0;
        ha_m[d] = '0;
        hd_m[d] = '0;
        acked[d][0] = 1'b0;
        acked[d][1] = 1'b0;
      end else begin
        acked[d][0] = (g[d] == 0);
        acked[d][1] = (g[d] == 1);
        pv_m[d] = 1'b0;
        if (g[d] >= 0) begin
          pv_m[d] = rq[d][g[d]].rnw;
          pp_m[d] = g[d];
          pk_m[d] = seen[d][rq[d][g[d]].addr];
          pd_m[d] = ref_mem[d][rq[d][g[d]].addr];
          last_port[d] = g[d];
          ha_m[d] = rq[d][g[d]].addr;
          hd_m[d] = rq[d][g[d]].wdata;
          if (!rq[d][g[d]].rnw) begin
            ref_mem[d][rq[d][g[d]].addr] = rq[d][g[d]].wdata;
            seen[d][rq[d][g[d]].addr]    = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic setr(input int d, input int p, input logic req, input logic rnw,
                      input logic [AW-1:0] a, input logic [DW-1:0] w);
    rq[d][p].req   = req;
    rq[d][p].rnw   = rnw;
    rq[d][p].addr  = a;
    rq[d][p].wdata = w;
  endtask

  task automatic both(input int p, input logic req, input logic rnw,
                      input logic [AW-1:0] a, input logic [DW-1:0] w);
    setr(0, p, req, rnw, a, w);
    setr(1, p, req, rnw, a, w);
  endtask

  task automatic idle_all();
    both(0, 1'b0, 1'b1, '0, '0);
    both(1, 1'b0, 1'b1, '0, '0);
  endtask

  task automatic random_drive();
    if (!resetb) begin
      if ($urandom_range(0, 1) == 0) resetb = 1'b1;
    end else if ($urandom_range(0, 79) == 0) begin
      resetb = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq[d][p].req || acked[d][p]) begin
          if ($urandom_range(0, 3) != 0)
            setr(d, p, 1'b1, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7))
                                             : AW'(13'h1FF8 + $urandom_range(0, 7)),
                 DW'($urandom));
          else
            setr(d, p, 1'b0, 1'b1, '0, '0);
        end
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(DEPTH); i++) seen[d][i] = 1'b0;
      last_port[d] = 1;
      pv_m[d] = 1'b0; pp_m[d] = 0; pk_m[d] = 1'b0; pd_m[d] = '0;
      ha_m[d] = '0;   hd_m[d] = '0;
      acked[d][0] = 1'b0; acked[d][1] = 1'b0;
    end
    resetb = 1'b0;

    // reset held with both ports requesting
    both(0, 1'b1, 1'b1, 13'h0010, '0);
    both(1, 1'b1, 1'b1, 13'h1FFF, '0);
    repeat (3) cycle();
    resetb = 1'b1;
    cycle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_first_a_ack", d), 32'(lack[d][0]), 32'd1);
      check($sformatf("d%0d_first_b_ack", d), 32'(lack[d][1]), 32'd0);
    end
    both(0, 1'b0, 1'b1, '0, '0);
    cycle();
    idle_all();
    cycle();

    // port A write then read of the same word
    both(0, 1'b1, 1'b0, 13'h0123, 32'hDEADBEEF);
    cycle();
    both(0, 1'b1, 1'b1, 13'h0123, '0);
    cycle();
    idle_all();
    cycle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_wr_rd_rv", d), 32'(lrv[d][0]), 32'd1);
      check($sformatf("d%0d_wr_rd_data", d), lrd[d][0], 32'hDEADBEEF);
      check($sformatf("d%0d_wr_rd_brv", d), 32'(lrv[d][1]), 32'd0);
    end

    // preload, then sustained contention on reads
    both(0, 1'b1, 1'b0, 13'h0010, 32'h11111111);
    cycle();
    both(0, 1'b0, 1'b1, '0, '0);
    both(1, 1'b1, 1'b0, 13'h1FFF, 32'h22222222);
    cycle();
    both(0, 1'b1, 1'b1, 13'h0010, '0);
    both(1, 1'b1, 1'b1, 13'h1FFF, '0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("rr_cont_a_ack%0d", i), 32'(lack[0][0]), 32'(i % 2 == 0));
      check($sformatf("rr_cont_b_ack%0d", i), 32'(lack[0][1]), 32'(i % 2 == 1));
      check($sformatf("fx_cont_b_ack%0d", i), 32'(lack[1][1]), 32'd0);
      if (i > 0) begin
        if ((i - 1) % 2 == 0)
          check($sformatf("rr_cont_a_rd%0d", i), lrd[0][0], 32'h11111111);
        else
          check($sformatf("rr_cont_b_rd%0d", i), lrd[0][1], 32'h22222222);
        check($sformatf("fx_cont_a_rd%0d", i), lrd[1][0], 32'h11111111);
      end
    end
    both(0, 1'b0, 1'b1, '0, '0);
    cycle();
    check("fx_b_ack_after_a_drop", 32'(lack[1][1]), 32'd1);
    idle_all();
    cycle();
    cycle();

    // reset arriving right after a B read is accepted
    both(1, 1'b1, 1'b1, 13'h0004, '0);
    cycle();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_mid_b_ack", d), 32'(lack[d][1]), 32'd1);
    idle_all();
    resetb = 1'b0;
    cycle();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_mid_rv_n1", d), 32'(lrv[d][1]), 32'd0);
    cycle();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_mid_rv_n2", d), 32'(lrv[d][1]), 32'd0);
    resetb = 1'b1;
    cycle();
    cycle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_post_rst_brv", d), 32'(lrv[d][1]), 32'd0);
      check($sformatf("d%0d_post_rst_arv", d), 32'(lrv[d][0]), 32'd0);
    end

    // boundary addresses from port B
    both(1, 1'b1, 1'b0, 13'h0000, 32'hFFFFFFFF);
    cycle();
    both(1, 1'b1, 1'b0, 13'h1FFF, 32'h00000001);
    cycle();
    both(1, 1'b1, 1'b1, 13'h0000, '0);
    cycle();
    both(1, 1'b1, 1'b1, 13'h1FFF, '0);
    cycle();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_bnd_lo", d), lrd[d][1], 32'hFFFFFFFF);
    idle_all();
    cycle();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_bnd_hi", d), lrd[d][1], 32'h00000001);

    // randomized traffic with occasional resets
    repeat (600) begin
      random_drive();
      cycle();
    end
    resetb = 1'b1;
    idle_all();
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
